// File: rtl/load_store_unit.sv
// load_store_unit: big-endian byte/half/word LSU, registered memory side, read-modify-write sub-word stores.
// Optional LSU_STATS_EN adds saturating load/store/fault response counters.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rstN_i,
    input  logic        reqValid_i,
    output logic        reqReady_o,
    input  logic        reqStore_i,
    input  logic [2:0]  reqFunct3_i,
    input  logic [31:0] reqAddress_i,
    input  logic [31:0] reqData_i,
    output logic        respValid_o,
    input  logic        respReady_i,
    output logic [31:0] respData_o,
    output logic        respFault_o,
`ifdef LSU_STATS_EN
    output logic [15:0] statLoads_o,
    output logic [15:0] statStores_o,
    output logic [15:0] statFaults_o,
`endif
    output logic        memReadEnable_o,
    output logic        memWriteEnable_o,
    output logic [31:0] memAddress_o,
    output logic [31:0] memDataWrite_o,
    input  logic [31:0] memDataRead_i
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d, req_ready_q, req_ready_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] data_q, data_d;
    logic        mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        resp_valid_q, resp_valid_d, resp_fault_q, resp_fault_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic [31:0] base, load_val, merged;
    logic        bad_f3, misalign, fault, word_store;
    logic [4:0]  bsh, hsh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign base       = {reqAddress_i[31:2], 2'b00};
    assign bad_f3     = reqStore_i ? (reqFunct3_i[1:0] == 2'b11)
                                   : !(reqFunct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misalign   = (reqFunct3_i[1:0] == 2'b01 && reqAddress_i[0])
                     || (reqFunct3_i[1:0] == 2'b10 && reqAddress_i[1:0] != 2'b00);
    assign fault      = bad_f3 || misalign || (base >= 32'(MEM_BYTES));
    assign word_store = reqStore_i && reqFunct3_i[1:0] == 2'b10;

    // Big-endian lanes: byte offset 0 is the most significant byte.
    assign bsh      = {~off_q, 3'b000};
    assign hsh      = off_q[1] ? 5'd0 : 5'd16;
    assign byte_v   = 8'(memDataRead_i >> bsh);
    assign half_v   = off_q[1] ? memDataRead_i[15:0] : memDataRead_i[31:16];
    assign load_val = funct3_q[1:0] == 2'b10 ? memDataRead_i
                    : funct3_q[1:0] == 2'b01 ? {{16{~funct3_q[2] & half_v[15]}}, half_v}
                    : {{24{~funct3_q[2] & byte_v[7]}}, byte_v};
    assign merged   = funct3_q[1:0] == 2'b01
                    ? (memDataRead_i & ~(32'hFFFF << hsh)) | ({16'h0, data_q} << hsh)
                    : (memDataRead_i & ~(32'hFF << bsh)) | ({24'h0, data_q[7:0]} << bsh);

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        data_d       = data_q;
        req_ready_d  = 1'b0;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = 32'h0;
        mem_wdata_d  = 32'h0;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_data_d  = 32'h0;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (reqValid_i && req_ready_q) begin
                    store_d     = reqStore_i;
                    funct3_d    = reqFunct3_i;
                    off_d       = reqAddress_i[1:0];
                    data_d      = reqData_i[15:0];
                    req_ready_d = 1'b0;
                    if (fault) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (word_store) begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = base;
                        mem_wdata_d = reqData_i;
                    end else begin
                        state_d    = READ;
                        mem_re_d   = 1'b1;
                        mem_addr_d = base;
                    end
                end
            end
            READ: begin
                if (store_q) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = merged;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_val;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (respReady_i) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_fault_d = resp_fault_q;
                    resp_data_d  = resp_data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'b0;
            off_q        <= 2'b0;
            data_q       <= 16'h0;
            req_ready_q  <= 1'b1;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_data_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            data_q       <= data_d;
            req_ready_q  <= req_ready_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign reqReady_o       = req_ready_q;
    assign respValid_o      = resp_valid_q;
    assign respFault_o      = resp_fault_q;
    assign respData_o       = resp_data_q;
    assign memReadEnable_o  = mem_re_q;
    assign memWriteEnable_o = mem_we_q;
    assign memAddress_o     = mem_addr_q;
    assign memDataWrite_o   = mem_wdata_q;

`ifdef LSU_STATS_EN
    logic [15:0] loads_q, loads_d, stores_q, stores_d, faults_q, faults_d;
    logic        hs;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign hs = state_q == RESP && respReady_i;

    always_comb begin
        loads_d  = loads_q;
        stores_d = stores_q;
        faults_d = faults_q;
        if (hs && resp_fault_q) faults_d = sat_inc(faults_q);
        else if (hs && store_q) stores_d = sat_inc(stores_q);
        else if (hs) loads_d = sat_inc(loads_q);
    end

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            loads_q  <= 16'h0;
            stores_q <= 16'h0;
            faults_q <= 16'h0;
        end else begin
            loads_q  <= loads_d;
            stores_q <= stores_d;
            faults_q <= faults_d;
        end
    end

    assign statLoads_o  = loads_q;
    assign statStores_o = stores_q;
    assign statFaults_o = faults_q;
`endif
endmodule
